// File: rtl/board_input_ctrl_pkg.sv
// Shared constants, FSM encoding and grid helper for the board input controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package board_input_ctrl_pkg;

  localparam int TILE_W         = 2;
  localparam int SCREEN_W       = 640;
  localparam int SCREEN_H       = 480;
  localparam int CURSOR_RST_X   = 444;
  localparam int CURSOR_RST_Y   = 330;

  localparam int GRID_X0_DEF    = 293;
  localparam int GRID_Y0_DEF    = 104;
  localparam int TILE_DEF       = 85;
  localparam int ROWS_DEF       = 2;
  localparam int COLS_DEF       = 2;
  localparam int STEP_DEF       = 2;
  localparam int DEB_CYCLES_DEF = 500000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_SWAP = 2'd2
  } fsm_state_t;

  // True when two cells share a row or column and sit exactly one step apart.
  function automatic logic is_adjacent(input int ra, input int ca, input int rb, input int cb);
    return ((ra == rb) && ((ca - cb == 1) || (cb - ca == 1))) ||
           ((ca == cb) && ((ra - rb == 1) || (rb - ra == 1)));
  endfunction

endpackage

// File: rtl/board_input_ctrl_btn_debounce.sv
// Button conditioner: two-flop synchroniser followed by a stable-time debouncer.
// Latency: 2 sync cycles plus DEB_CYCLES cycles of stable differing input before o_level flips.
// Backpressure: none; o_level is a free-running registered level.
module board_input_ctrl_btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  // Synchronise the raw pin, then flip the level only after an unbroken run of disagreement.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/board_input_ctrl.sv
// Board input controller: button conditioning, per-frame cursor motion, two-click select/swap FSM.
// Latency: cursor moves on the frame_tick edge; selection and swap outputs register one cycle after a click event.
// Backpressure: none; outputs are registered levels plus a single-cycle swap pulse.
module board_input_ctrl
  import board_input_ctrl_pkg::*;
#(
  parameter int GRID_X0    = GRID_X0_DEF,
  parameter int GRID_Y0    = GRID_Y0_DEF,
  parameter int TILE       = TILE_DEF,
  parameter int ROWS       = ROWS_DEF,
  parameter int COLS       = COLS_DEF,
  parameter int STEP       = STEP_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_frame_tick,
  input  logic                           i_up,
  input  logic                           i_down,
  input  logic                           i_left,
  input  logic                           i_right,
  input  logic                           i_click,
  output logic [9:0]                     o_cursor_x,
  output logic [9:0]                     o_cursor_y,
  output logic [TILE_W*ROWS*COLS-1:0]    o_tile_map,
  output logic                           o_sel_valid,
  output logic [$clog2(ROWS*COLS)-1:0]   o_sel_idx,
  output logic                           o_swap_pulse
);

  localparam int NCELL = ROWS * COLS;
  localparam int IW    = $clog2(NCELL);
  localparam int MW    = TILE_W * NCELL;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic signed [10:0] X_MAX  = 11'(SCREEN_W - 1);
  localparam logic signed [10:0] Y_MAX  = 11'(SCREEN_H - 1);

  logic [4:0]         w_btn_raw;
  logic [4:0]         w_btn_deb;
  logic               w_up, w_down, w_left, w_right, w_click;
  logic               r_click_q;
  logic               w_click_ev;

  logic [9:0]         r_cursor_x, r_cursor_y;
  logic [9:0]         w_cursor_x_nxt, w_cursor_y_nxt;
  logic signed [10:0] w_dx, w_dy, w_x_sum, w_y_sum;

  logic               w_row_hit, w_col_hit, w_hit, w_hit_adj;
  logic [RW-1:0]      w_hit_row;
  logic [CW-1:0]      w_hit_col;
  logic [IW-1:0]      w_hit_idx;

  fsm_state_t         r_state, w_state_nxt;
  logic [MW-1:0]      r_tile_map, w_tile_map_nxt;
  logic               r_sel_valid, w_sel_valid_nxt;
  logic [IW-1:0]      r_sel_idx, w_sel_idx_nxt;
  logic [RW-1:0]      r_sel_row, w_sel_row_nxt;
  logic [CW-1:0]      r_sel_col, w_sel_col_nxt;
  logic               r_swap_pulse, w_swap_pulse_nxt;

  assign w_btn_raw = {i_click, i_right, i_left, i_down, i_up};

  for (genvar g = 0; g < 5; g++) begin : g_deb
    board_input_ctrl_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_btn   (w_btn_raw[g]),
      .o_level (w_btn_deb[g])
    );
  end

  assign w_up       = w_btn_deb[0];
  assign w_down     = w_btn_deb[1];
  assign w_left     = w_btn_deb[2];
  assign w_right    = w_btn_deb[3];
  assign w_click    = w_btn_deb[4];
  assign w_click_ev = w_click & ~r_click_q;

  // Remember the previous debounced click level to form a one-cycle press event.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_click_q <= 1'b0;
    else       r_click_q <= w_click;
  end

  // Signed step per axis (opposing buttons cancel), then saturate to the visible screen.
  always_comb begin
    w_dx = '0;
    w_dy = '0;
    if (w_left && !w_right)      w_dx = -STEP_S;
    else if (w_right && !w_left) w_dx = STEP_S;
    if (w_up && !w_down)         w_dy = -STEP_S;
    else if (w_down && !w_up)    w_dy = STEP_S;
    w_x_sum = $signed({1'b0, r_cursor_x}) + w_dx;
    w_y_sum = $signed({1'b0, r_cursor_y}) + w_dy;
    if (w_x_sum[10])          w_cursor_x_nxt = '0;
    else if (w_x_sum > X_MAX) w_cursor_x_nxt = X_MAX[9:0];
    else                      w_cursor_x_nxt = w_x_sum[9:0];
    if (w_y_sum[10])          w_cursor_y_nxt = '0;
    else if (w_y_sum > Y_MAX) w_cursor_y_nxt = Y_MAX[9:0];
    else                      w_cursor_y_nxt = w_y_sum[9:0];
  end

  // Cursor only moves on the frame tick so motion speed is tied to the display rate.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cursor_x <= 10'(CURSOR_RST_X);
      r_cursor_y <= 10'(CURSOR_RST_Y);
    end else if (i_frame_tick) begin
      r_cursor_x <= w_cursor_x_nxt;
      r_cursor_y <= w_cursor_y_nxt;
    end
  end

  // Range-compare the current (pre-move) cursor against each column and row band.
  always_comb begin
    w_col_hit = 1'b0;
    w_row_hit = 1'b0;
    w_hit_col = '0;
    w_hit_row = '0;
    for (int c = 0; c < COLS; c++) begin
      if (int'(r_cursor_x) >= GRID_X0 + c * TILE && int'(r_cursor_x) < GRID_X0 + (c + 1) * TILE) begin
        w_col_hit = 1'b1;
        w_hit_col = CW'(c);
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      if (int'(r_cursor_y) >= GRID_Y0 + r * TILE && int'(r_cursor_y) < GRID_Y0 + (r + 1) * TILE) begin
        w_row_hit = 1'b1;
        w_hit_row = RW'(r);
      end
    end
    w_hit     = w_row_hit & w_col_hit;
    w_hit_idx = IW'(int'(w_hit_row) * COLS + int'(w_hit_col));
    w_hit_adj = is_adjacent(int'(r_sel_row), int'(r_sel_col), int'(w_hit_row), int'(w_hit_col));
  end

  // Next-state and next-output logic; the swap is committed on the same edge that enters SWAP.
  always_comb begin
    w_state_nxt      = r_state;
    w_tile_map_nxt   = r_tile_map;
    w_sel_valid_nxt  = r_sel_valid;
    w_sel_idx_nxt    = r_sel_idx;
    w_sel_row_nxt    = r_sel_row;
    w_sel_col_nxt    = r_sel_col;
    w_swap_pulse_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_click_ev && w_hit) begin
          w_state_nxt     = ST_SEL;
          w_sel_valid_nxt = 1'b1;
          w_sel_idx_nxt   = w_hit_idx;
          w_sel_row_nxt   = w_hit_row;
          w_sel_col_nxt   = w_hit_col;
        end
      end
      ST_SEL: begin
        if (w_click_ev) begin
          if (!w_hit || (w_hit_idx == r_sel_idx)) begin
            w_state_nxt     = ST_IDLE;
            w_sel_valid_nxt = 1'b0;
          end else if (w_hit_adj) begin
            w_state_nxt      = ST_SWAP;
            w_sel_valid_nxt  = 1'b0;
            w_swap_pulse_nxt = 1'b1;
            w_tile_map_nxt[TILE_W*int'(r_sel_idx) +: TILE_W] = r_tile_map[TILE_W*int'(w_hit_idx) +: TILE_W];
            w_tile_map_nxt[TILE_W*int'(w_hit_idx) +: TILE_W] = r_tile_map[TILE_W*int'(r_sel_idx) +: TILE_W];
          end else begin
            w_sel_idx_nxt = w_hit_idx;
            w_sel_row_nxt = w_hit_row;
            w_sel_col_nxt = w_hit_col;
          end
        end
      end
      ST_SWAP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset restores the column-pattern board and drops any selection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_sel_valid  <= 1'b0;
      r_sel_idx    <= '0;
      r_sel_row    <= '0;
      r_sel_col    <= '0;
      r_swap_pulse <= 1'b0;
      for (int i = 0; i < NCELL; i++) begin
        r_tile_map[TILE_W*i +: TILE_W] <= TILE_W'(i % COLS);
      end
    end else begin
      r_state      <= w_state_nxt;
      r_tile_map   <= w_tile_map_nxt;
      r_sel_valid  <= w_sel_valid_nxt;
      r_sel_idx    <= w_sel_idx_nxt;
      r_sel_row    <= w_sel_row_nxt;
      r_sel_col    <= w_sel_col_nxt;
      r_swap_pulse <= w_swap_pulse_nxt;
    end
  end

  assign o_cursor_x   = r_cursor_x;
  assign o_cursor_y   = r_cursor_y;
  assign o_tile_map   = r_tile_map;
  assign o_sel_valid  = r_sel_valid;
  assign o_sel_idx    = r_sel_idx;
  assign o_swap_pulse = r_swap_pulse;

endmodule
